// File: rtl/load_extract_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_extract_unit
//  Purpose  : Load-side lane extractor. Accepts a byte / halfword / word load
//             request, issues a single aligned word read to data memory,
//             waits for the reply (bounded by TIMEOUT), then selects the
//             addressed little-endian lane and zero- or sign-extends it to
//             32 bits. Misaligned or illegal requests are answered with an
//             error and never reach memory.
//  Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//             req_valid/req_ready - load request handshake
//             req_addr/req_size/req_signed - byte address, size code, extend mode
//             mem_rd_en/mem_addr  - one-cycle aligned read strobe and address
//             mem_rd_valid/mem_rdata - read reply
//             resp_valid/resp_ready - response handshake
//             resp_data/resp_err  - extended result and error flag
//  Config   : LOAD_HALF_EN - when defined, halfword loads are supported;
//             otherwise size 01 is rejected like size 11.
//  Revision : 1.0 - initial release
// ============================================================================
module load_extract_unit #(
    parameter int unsigned TIMEOUT = 15     // 1..255 WAIT cycles before abandon
) (
    input  logic        clk,
    input  logic        rst_n,
    // request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    // data-memory read port
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rdata,
    // response side
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic [1:0]  size_q;
    logic [1:0]  size_d;
    logic        signed_q;
    logic        signed_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic        err_q;
    logic        err_d;

    logic        req_legal;
    logic [7:0]  byte_sel;
    logic [31:0] load_ext;
`ifdef LOAD_HALF_EN
    logic [15:0] half_sel;
`endif

    // ------------------------------------------------------------------------
    // Request legality: decided on the live request so a rejected access goes
    // straight to RESP without ever strobing memory.
    // ------------------------------------------------------------------------
    always_comb begin
        req_legal = 1'b0;
        case (req_size)
            SIZE_BYTE: req_legal = 1'b1;
`ifdef LOAD_HALF_EN
            SIZE_HALF: req_legal = ~req_addr[0];
`else
            SIZE_HALF: req_legal = 1'b0;
`endif
            SIZE_WORD: req_legal = (req_addr[1:0] == 2'b00);
            default:   req_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Lane selection and extension from the captured request and the live
    // read word; only consumed in WAIT when the reply arrives.
    // ------------------------------------------------------------------------
    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
    end

`ifdef LOAD_HALF_EN
    always_comb begin
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end
`endif

    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            SIZE_BYTE: load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
`ifdef LOAD_HALF_EN
            SIZE_HALF: load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
`endif
            default:   load_ext = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        addr_d    = addr_q;
        size_d    = size_q;
        signed_d  = signed_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        err_d     = err_q;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    cnt_d    = 8'd0;
                    data_d   = 32'd0;
                    if (req_legal) begin
                        err_d     = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        err_d     = 1'b1;
                        state_nxt = RESP;
                    end
                end
            end
            REQ: begin
                cnt_d     = 8'd0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A reply in the same cycle the counter expires still wins.
                if (mem_rd_valid) begin
                    data_d    = load_ext;
                    err_d     = 1'b0;
                    state_nxt = RESP;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    data_d    = 32'd0;
                    err_d     = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= 32'd0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            cnt_q    <= 8'd0;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_ready  = (state == IDLE);
    assign mem_rd_en  = (state == REQ);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign resp_valid = (state == RESP);
    assign resp_data  = data_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: doc/load_extract_unit.md
# load_extract_unit

Load-side counterpart of the store-byte merge path: accepts a load request (byte, halfword or word at a byte address), issues one aligned word read to data memory, waits for the reply, then selects the addressed lane and zero- or sign-extends it to 32 bits. It sits between the execute stage and the data-memory read port. It returns the result through a valid/ready response handshake. Misaligned or illegal requests are rejected with an error and never touch memory.

## Interface
Parameters:
- TIMEOUT, 15: maximum WAIT cycles before the access is abandoned with an error; range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  load request present.
- req_ready  output  1  block can accept a request; equals (state==IDLE).
- req_addr  input  32  byte address.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  input  1  1 = sign-extend, 0 = zero-extend; ignored for word.
- mem_rd_en  output  1  one-cycle read strobe.
- mem_addr  output  32  word-aligned address: {addr[31:2],2'b00}.
- mem_rd_valid  input  1  read data valid.
- mem_rdata  input  32  read word.
- resp_valid  output  1  result available; held until it is accepted.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  32  extended load result.
- resp_err  output  1  misaligned, illegal or timed-out access; qualified by resp_valid.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: when req_valid is high, capture addr, size and signed.
  - If legal and aligned, go to REQ.
  - Otherwise go to RESP with resp_err=1 and resp_data=0.
- Alignment rules:
  - Byte: always legal.
  - Halfword: addr[0] must be 0.
  - Word: addr[1:0] must be 00.
  - Size 11: illegal.
- REQ: mem_rd_en=1 with mem_addr valid for exactly one cycle; then go to WAIT with the timeout counter cleared.
- WAIT: sample mem_rd_valid each cycle.
  - mem_rd_valid high: register the extracted data, resp_err=0, go to RESP.
  - Otherwise, if the counter has reached TIMEOUT: resp_err=1, resp_data=0, go to RESP.
  - Otherwise increment the counter.
- RESP: resp_valid=1. When resp_ready is high, go to IDLE.
- Byte lane selection (little-endian, same lane map as the store merge):
  - addr[1:0]=00 → [7:0]
  - 01 → [15:8]
  - 10 → [23:16]
  - 11 → [31:24]
- Halfword selection: addr[1]=0 → [15:0], addr[1]=1 → [31:16].
- Extension: signed replicates the selected MSB into the upper bits; unsigned fills with zeros.
- mem_rd_valid is ignored in IDLE, REQ and RESP. A reply arriving after a timeout or after a reset is dropped.
- Exactly one outstanding memory read at any time.

## Timing
- Reset values:
  - state IDLE, req_ready=1.
  - mem_rd_en=0, mem_addr=0.
  - resp_valid=0, resp_data=0, resp_err=0.
  - Counter 0.
- Aligned load:
  - Accept at cycle 0; mem_rd_en at cycle 1.
  - If mem_rd_valid arrives at cycle 2, resp_valid goes high at cycle 3.
  - Minimum accept-to-response latency is 3 cycles.
- Rejected request: accepted at cycle 0, resp_valid at cycle 1; mem_rd_en never asserts.
- Timeout: with no reply, resp_valid with resp_err asserts TIMEOUT+3 cycles after accept.
- resp_valid, resp_data and resp_err stay stable while resp_ready=0.
- Back-to-back: the next request can be accepted the cycle after the RESP handshake.
- Reset asserted mid-operation: immediate return to IDLE and all outputs to their reset values. Any pending memory reply is ignored.

## Configuration
- LOAD_HALF_EN defined: halfword loads are supported as above.
- LOAD_HALF_EN undefined: req_size=01 is treated as illegal (error response, no memory access), and the halfword select logic is not built.

## Test plan
- Byte load, signed: mem_rdata=0x12C3_8055, addr=0x101, reply 1 cycle after mem_rd_en → mem_addr=0x100, resp_data=0xFFFF_FF80, resp_err=0; unsigned → 0x0000_0080.
- Halfword load (LOAD_HALF_EN), signed: addr=0x202, mem_rdata=0x8001_7FFF → resp_data=0xFFFF_8001. With the macro undefined, the same request → resp_err=1, no mem_rd_en.
- Misaligned word: addr=0x6, size 10 → resp_valid at cycle 1, resp_err=1, resp_data=0, mem_rd_en never high.
- Timeout: TIMEOUT=4, mem_rd_valid held low → resp_err=1 at accept+7. A mem_rd_valid pulse one cycle later does not change the response.
- Backpressure and back-to-back: hold resp_ready=0 for 5 cycles → outputs stable; release, then the second request is accepted on the next cycle and returns correct data.
- Reset mid-WAIT: drop rst_n during WAIT, then deliver mem_rd_valid after release → no resp_valid, req_ready=1, all outputs at reset values.
